// File: rtl/ip_uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes, FSM
// states and the baud divisor rounding helper (also meant for the receiver).
package ip_uart_tx_fifo_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_freq, input int uart_freq);
        return (clk_freq + uart_freq / 2) / uart_freq;
    endfunction

endpackage

// File: rtl/ip_uart_tx_fifo_if.sv
// Producer-side enqueue handshake of the buffered UART transmitter.
interface ip_uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] send_data;
    logic                 send_req;
    logic                 send_ready;

    modport master (
        output send_data,
        output send_req,
        input  send_ready
    );

    modport slave (
        input  send_data,
        input  send_req,
        output send_ready
    );
endinterface

// File: rtl/ip_uart_tx_fifo_fifo.sv
// Single-clock FIFO with register-array storage; the head word is read
// combinationally so the transmitter can load it on the popping edge.
module ip_uart_tx_fifo_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ip_uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and are serialised
// back-to-back with configurable data width, parity and stop bits.
module ip_uart_tx_fifo
    import ip_uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ        = 27000000,
    parameter int UART_FREQ       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    ip_uart_tx_fifo_if.slave         send,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     busy,
    output logic                     uart_tx
);
    localparam int DIV   = baud_div(CLK_FREQ, UART_FREQ);
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN)) begin : g_param_check
        $error("ip_uart_tx_fifo: illegal parameter combination");
    end

    uart_state_t          state;
    uart_state_t          state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 par_bit;
    logic                 par_bit_next;
    logic                 tx_next;
    logic                 busy_next;
    logic                 bit_end;
    logic                 load;
    logic                 push;
    logic                 full;
    logic                 empty;
    logic                 frame_parity;
    logic [DATA_BITS-1:0] head;

    assign push             = send.send_req & ~full;
    assign send.send_ready  = ~full;
    assign bit_end          = (cnt == CNT_LAST);
    assign frame_parity     = (PARITY == PAR_ODD) ? ~(^head) : ^head;

    ip_uart_tx_fifo_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .pop     (load),
        .wdata   (send.send_data),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            par_bit <= par_bit_next;
            uart_tx <= tx_next;
            busy    <= busy_next;
        end
    end

    // The last stop bit chains straight into the next start bit when more words wait.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!empty) state_next = ST_START;
            ST_START:  if (bit_end) state_next = ST_DATA;
            ST_DATA:   if (bit_end && bit_idx == DATA_LAST)
                           state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            ST_STOP:   if (bit_end && bit_idx == STOP_LAST)
                           state_next = empty ? ST_IDLE : ST_START;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The line is registered; shift[0] always holds the next data bit to drive.
    always_comb begin
        load         = (state == ST_IDLE && !empty) ||
                       (state == ST_STOP && state_next == ST_START);
        cnt_next     = (state == ST_IDLE || bit_end) ? '0 : cnt + 1'b1;
        bit_idx_next = (state_next != state) ? '0 : (bit_end ? bit_idx + 1'b1 : bit_idx);
        shift_next   = shift;
        par_bit_next = par_bit;
        tx_next      = uart_tx;
        if (load) begin
            shift_next   = head;
            par_bit_next = frame_parity;
            tx_next      = 1'b0;
        end else if (bit_end) begin
            case (state_next)
                ST_DATA: begin
                    tx_next    = shift[0];
                    shift_next = shift >> 1;
                end
                ST_PARITY: tx_next = par_bit;
                ST_STOP:   tx_next = 1'b1;
                ST_IDLE:   tx_next = 1'b1;
                default:   tx_next = uart_tx;
            endcase
        end
        busy_next = (state_next != ST_IDLE) | push | (fifo_count != '0);
    end
endmodule

// File: tb/tb_ip_uart_tx_fifo.sv
// Bench for ip_uart_tx_fifo: a frame-level model checks the 8N1 instance every
// cycle; parity and two-stop variants are checked against rule-built waveforms.
module tb_ip_uart_tx_fifo;
    logic clk;
    logic n_reset;
    bit   model_on;
    int   errors;
    int   checks;

    logic [4:0] fifo_count_m, fifo_count_e, fifo_count_o, fifo_count_t;
    logic       busy_m, busy_e, busy_o, busy_t;
    logic       uart_tx_m, uart_tx_e, uart_tx_o, uart_tx_t;

    ip_uart_tx_fifo_if #(.DATA_BITS(8)) bif_m ();
    ip_uart_tx_fifo_if #(.DATA_BITS(7)) bif_e ();
    ip_uart_tx_fifo_if #(.DATA_BITS(7)) bif_o ();
    ip_uart_tx_fifo_if #(.DATA_BITS(8)) bif_t ();

    ip_uart_tx_fifo #(.CLK_FREQ(1000), .UART_FREQ(100), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(1), .FIFO_DEPTH_LOG2(4)) u_main (
        .clk(clk), .n_reset(n_reset), .send(bif_m),
        .fifo_count(fifo_count_m), .busy(busy_m), .uart_tx(uart_tx_m));

    ip_uart_tx_fifo #(.CLK_FREQ(1000), .UART_FREQ(100), .DATA_BITS(7), .PARITY(2),
                      .STOP_BITS(1), .FIFO_DEPTH_LOG2(4)) u_even (
        .clk(clk), .n_reset(n_reset), .send(bif_e),
        .fifo_count(fifo_count_e), .busy(busy_e), .uart_tx(uart_tx_e));

    ip_uart_tx_fifo #(.CLK_FREQ(1000), .UART_FREQ(100), .DATA_BITS(7), .PARITY(1),
                      .STOP_BITS(1), .FIFO_DEPTH_LOG2(4)) u_odd (
        .clk(clk), .n_reset(n_reset), .send(bif_o),
        .fifo_count(fifo_count_o), .busy(busy_o), .uart_tx(uart_tx_o));

    ip_uart_tx_fifo #(.CLK_FREQ(1000), .UART_FREQ(100), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(2), .FIFO_DEPTH_LOG2(4)) u_two (
        .clk(clk), .n_reset(n_reset), .send(bif_t),
        .fifo_count(fifo_count_t), .busy(busy_t), .uart_tx(uart_tx_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model of the 8N1 instance: a word queue plus time into the current frame.
    logic [7:0] mq[$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_word;
    bit         m_push;

    function automatic logic model_line(input logic [7:0] w, input int t);
        if (t < 10) return 1'b0;
        if (t < 90) return w[(t - 10) / 10];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            m_push = bif_m.send_req && (mq.size() < 16);
            if (m_active) begin
                m_t++;
                if (m_t == 100) m_active = 1'b0;
            end
            if (!m_active && mq.size() != 0) begin
                m_word   = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (m_push) mq.push_back(bif_m.send_data);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check_output("model_tx", int'(uart_tx_m),
                         int'(m_active ? model_line(m_word, m_t) : 1'b1));
            check_output("model_count", int'(fifo_count_m), mq.size());
            check_output("model_ready", int'(bif_m.send_ready), int'(mq.size() < 16));
            check_output("model_busy", int'(busy_m), int'(m_active || mq.size() != 0));
        end
    end

    task automatic apply_stimulus(input int which, input logic req, input logic [7:0] d);
        case (which)
            0: begin bif_m.send_req = req; bif_m.send_data = d;      end
            1: begin bif_e.send_req = req; bif_e.send_data = d[6:0]; end
            2: begin bif_o.send_req = req; bif_o.send_data = d[6:0]; end
            default: begin bif_t.send_req = req; bif_t.send_data = d; end
        endcase
    endtask

    function automatic logic tx_of(input int which);
        case (which)
            1: return uart_tx_e;
            2: return uart_tx_o;
            default: return uart_tx_t;
        endcase
    endfunction

    function automatic logic busy_of(input int which);
        case (which)
            1: return busy_e;
            2: return busy_o;
            default: return busy_t;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy_m && n < budget) begin
            step();
            n++;
        end
        check_output(tag, int'(busy_m), 0);
    endtask

    // Pushes one or two words into a secondary instance and checks every line cycle
    // against a waveform built from the frame format; pin_t/pin_v is a hand-computed point.
    task automatic run_frames(input int which, input int nwords, input logic [7:0] w0,
                              input logic [7:0] w1, input int nbits, input int par,
                              input int stops, input string tag, input int len,
                              input int pin_t, input logic pin_v);
        logic bits[$];
        logic [7:0] d;
        int ones;
        logic expv;
        for (int w = 0; w < nwords; w++) begin
            d    = (w == 0) ? w0 : w1;
            ones = 0;
            bits.push_back(1'b0);
            for (int i = 0; i < nbits; i++) begin
                bits.push_back(d[i]);
                ones += int'(d[i]);
            end
            if (par == 1) bits.push_back(ones % 2 == 0);
            if (par == 2) bits.push_back(ones % 2 == 1);
            for (int s = 0; s < stops; s++) bits.push_back(1'b1);
        end
        apply_stimulus(which, 1'b1, w0);
        step();
        apply_stimulus(which, nwords > 1, w1);
        check_output({tag, "_pre_start"}, int'(tx_of(which)), 1);
        step();
        apply_stimulus(which, 1'b0, 8'h00);
        for (int c = 0; c < len; c++) begin
            expv = (c / 10 < bits.size()) ? bits[c / 10] : 1'b1;
            check_output({tag, "_line"}, int'(tx_of(which)), int'(expv));
            check_output({tag, "_busy"}, int'(busy_of(which)), 1);
            if (c == pin_t) check_output({tag, "_pin"}, int'(tx_of(which)), int'(pin_v));
            step();
        end
        check_output({tag, "_busy_fall"}, int'(busy_of(which)), 0);
        check_output({tag, "_idle_line"}, int'(tx_of(which)), 1);
    endtask

    initial begin
        logic [9:0] lit48;
        errors   = 0;
        checks   = 0;
        model_on = 1'b0;
        for (int k = 0; k < 4; k++) apply_stimulus(k, 1'b0, 8'h00);
        n_reset = 1'b1;
        #1;
        n_reset  = 1'b0;
        model_on = 1'b1;
        #2;
        check_output("reset_tx", int'(uart_tx_m), 1);
        check_output("reset_ready", int'(bif_m.send_ready), 1);
        check_output("reset_count", int'(fifo_count_m), 0);
        check_output("reset_busy", int'(busy_m), 0);
        repeat (3) @(posedge clk);
        #3;
        n_reset = 1'b1;
        step();

        // 8N1 single word: start bit one clock after acceptance, 100-clock frame.
        lit48 = 10'b1_01001000_0;
        apply_stimulus(0, 1'b1, 8'h48);
        step();
        apply_stimulus(0, 1'b0, 8'h00);
        check_output("t1_pre_start", int'(uart_tx_m), 1);
        step();
        for (int c = 0; c <= 100; c++) begin
            if (c % 10 == 5) check_output("t1_bit", int'(uart_tx_m), int'(lit48[c / 10]));
            if (c == 99) check_output("t1_busy_end", int'(busy_m), 1);
            if (c == 100) check_output("t1_busy_fall", int'(busy_m), 0);
            if (c < 100) step();
        end

        // Twenty held requests into a 16-deep FIFO while the first word transmits.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(0, 1'b1, 8'(i));
            step();
            if (i == 16) begin
                check_output("t2_count_full", int'(fifo_count_m), 16);
                check_output("t2_ready_low", int'(bif_m.send_ready), 0);
            end
        end
        apply_stimulus(0, 1'b0, 8'h00);
        check_output("t2_dropped", int'(fifo_count_m), 16);
        repeat (72) step();
        check_output("t2_stop_begin", int'(uart_tx_m), 1);
        repeat (9) step();
        check_output("t2_stop_end", int'(uart_tx_m), 1);
        step();
        check_output("t2_next_start", int'(uart_tx_m), 0);
        repeat (10) step();
        check_output("t2_word1_bit0", int'(uart_tx_m), 1);
        wait_idle(2000, "t2_drain");
        check_output("t2_count_empty", int'(fifo_count_m), 0);

        // Simultaneous push and pop with three words queued.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 1'b1, 8'(8'hA0 + i));
            step();
        end
        apply_stimulus(0, 1'b0, 8'h00);
        check_output("t5_count_init", int'(fifo_count_m), 3);
        repeat (97) step();
        check_output("t5_count_before", int'(fifo_count_m), 3);
        apply_stimulus(0, 1'b1, 8'hEE);
        step();
        apply_stimulus(0, 1'b0, 8'h00);
        check_output("t5_count_same", int'(fifo_count_m), 3);
        check_output("t5_restart", int'(uart_tx_m), 0);
        wait_idle(600, "t5_drain");

        run_frames(1, 1, 8'h55, 8'h00, 7, 2, 1, "t3_even", 100, 85, 1'b0);
        run_frames(2, 1, 8'h55, 8'h00, 7, 1, 1, "t3_odd", 100, 85, 1'b1);
        run_frames(3, 2, 8'hA5, 8'h3C, 8, 0, 2, "t4_two_stop", 220, 110, 1'b0);

        // Reset in the middle of a data bit with five words waiting.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 1'b1, 8'(8'h10 + i));
            step();
        end
        apply_stimulus(0, 1'b0, 8'h00);
        check_output("t6_count_queued", int'(fifo_count_m), 5);
        repeat (30) step();
        #2;
        n_reset = 1'b0;
        #1;
        check_output("t6_tx_high", int'(uart_tx_m), 1);
        check_output("t6_count_zero", int'(fifo_count_m), 0);
        check_output("t6_busy_low", int'(busy_m), 0);
        check_output("t6_ready_high", int'(bif_m.send_ready), 1);
        repeat (3) @(posedge clk);
        #3;
        n_reset = 1'b1;
        repeat (150) step();
        check_output("t6_after_tx", int'(uart_tx_m), 1);
        check_output("t6_after_busy", int'(busy_m), 0);
        check_output("t6_after_count", int'(fifo_count_m), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
